// File: rtl/key_event_pkg.sv
// Shared types and width helpers for the key event generator.
//   ke_state_t : per-channel event FSM state
//   cnt_w()    : counter width helper, never returns less than 1
package key_event_pkg;

    typedef enum logic [1:0] {
        KE_IDLE,
        KE_PRESSED,
        KE_HELD
    } ke_state_t;

    // Width of a counter that must hold values up to n-1 (at least 1 bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Default-parameter widths, for reference by integrators
    localparam int unsigned KE_DEB_W_DEF   = cnt_w(20 + 1);
    localparam int unsigned KE_HOLD_W_DEF  = cnt_w(800 + 1);
    localparam int unsigned KE_REP_W_DEF   = cnt_w(100 + 1);
    localparam int unsigned KE_PRESC_W_DEF = cnt_w(50000000 / 1000);

endpackage

// File: rtl/key_event_channel.sv
// One key channel: 2-FF synchroniser, ms-tick debounce, and the
// press / release / long-press / auto-repeat event FSM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ms_tick      : shared 1 ms strobe, one clk wide
//   key          : raw key, active-low, asynchronous
//   key_state    : debounced level (1 = released)
//   press        : one-clk pulse on accepted press
//   release_evt  : one-clk pulse on accepted release
//   long_press   : one-clk pulse when hold time reaches LONG_MS
//   repeat_evt   : one-clk pulse every REPEAT_MS after long_press
module key_event_channel
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 800,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic key,
    output logic key_state,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt
);

    localparam int unsigned DW = cnt_w(DEBOUNCE_MS + 1);
    localparam int unsigned HW = cnt_w(LONG_MS + 1);
    localparam int unsigned RW = cnt_w(REPEAT_MS + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [DW-1:0] deb_cnt;

    ke_state_t     state;
    ke_state_t     state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nx;
    logic          press_nx;
    logic          release_nx;
    logic          long_nx;
    logic          repeat_nx;

    // Two-stage synchroniser; resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_MS consecutive ticks of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            key_state <= 1'b1;
        end else if (sync_q2 == key_state) begin
            deb_cnt <= '0;
        end else if (ms_tick) begin
            if (deb_cnt == DW'(DEBOUNCE_MS - 1)) begin
                key_state <= sync_q2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Event FSM state, counters and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= KE_IDLE;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            rep_cnt     <= rep_nx;
            press       <= press_nx;
            release_evt <= release_nx;
            long_press  <= long_nx;
            repeat_evt  <= repeat_nx;
        end
    end

    // Next-state and pulse decode; a release always wins over a tick
    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        rep_nx     = rep_cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        case (state)
            KE_IDLE: begin
                // key_state is 1 whenever IDLE is entered, so a 0 here is a falling edge
                if (!key_state) begin
                    press_nx = 1'b1;
                    hold_nx  = '0;
                    state_nx = KE_PRESSED;
                end
            end
            KE_PRESSED: begin
                if (key_state) begin
                    release_nx = 1'b1;
                    state_nx   = KE_IDLE;
                end else if (ms_tick) begin
                    if (hold_cnt == HW'(LONG_MS - 1)) begin
                        long_nx  = 1'b1;
                        rep_nx   = '0;
                        state_nx = KE_HELD;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
            end
            KE_HELD: begin
                if (key_state) begin
                    release_nx = 1'b1;
                    state_nx   = KE_IDLE;
                end else if (ms_tick) begin
                    if (rep_cnt == RW'(REPEAT_MS - 1)) begin
                        repeat_nx = 1'b1;
                        rep_nx    = '0;
                    end else begin
                        rep_nx = rep_cnt + RW'(1);
                    end
                end
            end
            default: state_nx = KE_IDLE;
        endcase
    end

endmodule

// File: rtl/key_event_gen.sv
// Key conditioning front end: shared 1 ms prescaler feeding N_KEYS
// independent debounce/event channels.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   key          : raw keys, active-low, asynchronous
//   key_state    : debounced levels (1 = released)
//   press        : per-key one-clk press pulses
//   release_evt  : per-key one-clk release pulses
//   long_press   : per-key one-clk long-press pulses
//   repeat_evt   : per-key one-clk auto-repeat pulses
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int unsigned F_CLK       = 50000000,
    parameter int unsigned N_KEYS      = 6,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 800,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_evt,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_evt
);

    localparam int unsigned MS_CYCLES = F_CLK / 1000;
    localparam int unsigned PW        = cnt_w(MS_CYCLES);

    logic [PW-1:0] presc;
    logic          ms_tick;

    // Tick is high for the single cycle in which the prescaler wraps
    assign ms_tick = (presc == PW'(MS_CYCLES - 1));

    // 1 ms prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (ms_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // One channel per key, all sharing ms_tick
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_event_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ms_tick     (ms_tick),
            .key         (key[i]),
            .key_state   (key_state[i]),
            .press       (press[i]),
            .release_evt (release_evt[i]),
            .long_press  (long_press[i]),
            .repeat_evt  (repeat_evt[i])
        );
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random key
// activity, compared every cycle against a tick-counting reference model.
module tb_key_event_gen;

    localparam int unsigned N      = 6;
    localparam int unsigned FCLK   = 10000;
    localparam int unsigned DEB    = 3;
    localparam int unsigned LONG   = 10;
    localparam int unsigned REP    = 4;
    localparam int          MS_CYC = FCLK / 1000;

    logic         clk;
    logic         rst;
    logic [N-1:0] key;
    logic [N-1:0] key_state;
    logic [N-1:0] press;
    logic [N-1:0] release_evt;
    logic [N-1:0] long_press;
    logic [N-1:0] repeat_evt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int           phase;
    logic [N-1:0] m_s1, m_s2, m_ks;
    int           m_run  [N];
    bit           m_act  [N];
    int           m_held [N];
    logic [N-1:0] e_press, e_rel, e_long, e_rep;

    // Observed pulse tallies and first-occurrence stamps
    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_long  [N];
    int cnt_rep   [N];
    int st_press  [N];
    int st_long   [N];

    key_event_gen #(
        .F_CLK       (FCLK),
        .N_KEYS      (N),
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .REPEAT_MS   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_state   (key_state),
        .press       (press),
        .release_evt (release_evt),
        .long_press  (long_press),
        .repeat_evt  (repeat_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model of one clock edge: held time is tracked as ticks since press,
    // long press at LONG ticks, repeats at every REP ticks beyond that
    task automatic model_edge(input logic r, input logic [N-1:0] k);
        logic         tick;
        logic [N-1:0] old_s2, old_ks;
        if (r) begin
            phase = 0;
            m_s1 = '1; m_s2 = '1; m_ks = '1;
            e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_act[i] = 0; m_held[i] = 0;
            end
        end else begin
            tick   = (phase == MS_CYC - 1);
            phase  = (phase + 1) % MS_CYC;
            old_s2 = m_s2;
            old_ks = m_ks;
            m_s2   = m_s1;
            m_s1   = k;
            e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
            for (int i = 0; i < N; i++) begin
                if (old_s2[i] != old_ks[i]) begin
                    if (tick) begin
                        m_run[i]++;
                        if (m_run[i] == int'(DEB)) begin
                            m_ks[i]  = old_s2[i];
                            m_run[i] = 0;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (!m_act[i]) begin
                    if (!old_ks[i]) begin
                        e_press[i] = 1'b1; m_act[i] = 1; m_held[i] = 0;
                    end
                end else if (old_ks[i]) begin
                    e_rel[i] = 1'b1; m_act[i] = 0;
                end else if (tick) begin
                    m_held[i]++;
                    if (m_held[i] == int'(LONG))
                        e_long[i] = 1'b1;
                    else if (m_held[i] > int'(LONG) && ((m_held[i] - int'(LONG)) % int'(REP)) == 0)
                        e_rep[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0; cnt_rep[i] = 0;
            st_press[i] = -1; st_long[i] = -1;
        end
    endtask

    // Advance n clocks, checking every output against the model each cycle
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge(rst, key);
            #1;
            cyc++;
            chk("key_state",   32'(key_state),   32'(m_ks));
            chk("press",       32'(press),       32'(e_press));
            chk("release",     32'(release_evt), 32'(e_rel));
            chk("long_press",  32'(long_press),  32'(e_long));
            chk("repeat",      32'(repeat_evt),  32'(e_rep));
            for (int i = 0; i < N; i++) begin
                if (press[i] === 1'b1) begin
                    cnt_press[i]++;
                    if (st_press[i] < 0) st_press[i] = cyc;
                end
                if (release_evt[i] === 1'b1) cnt_rel[i]++;
                if (long_press[i] === 1'b1) begin
                    cnt_long[i]++;
                    if (st_long[i] < 0) st_long[i] = cyc;
                end
                if (repeat_evt[i] === 1'b1) cnt_rep[i]++;
            end
        end
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        key = '0;
        clear_counts();

        // 1: reset with all keys pressed, then one press per key after debounce
        step(5);
        chk("reset_key_state", 32'(key_state), 32'h3F);
        chk("reset_pulses", 32'(press | release_evt | long_press | repeat_evt), 32'h0);
        rst = 1'b0;
        step(29);
        chk("no_early_press", 32'(cnt_press[0] + cnt_press[5]), 32'd0);
        step(31);
        for (int i = 0; i < N; i++) chk("s1_press_once", 32'(cnt_press[i]), 32'd1);
        key = '1;
        step(60);
        for (int i = 0; i < N; i++) chk("s1_release_once", 32'(cnt_rel[i]), 32'd1);

        // 2: bouncing key[0] with random short intervals, then held low
        clear_counts();
        for (int t = 0; t < 60; t += 4) begin
            key[0] = ~key[0];
            step(4);
        end
        for (int t = 0; t < 8; t++) begin
            key[0] = ~key[0];
            step(int'($urandom_range(1, 9)));
        end
        chk("s2_bounce_no_event", 32'(cnt_press[0] + cnt_rel[0]), 32'd0);
        key[0] = 1'b0;
        step(60);
        chk("s2_press_once", 32'(cnt_press[0]), 32'd1);
        key[0] = 1'b1;
        step(60);

        // 3: key[1] long hold, long press then seven repeats, one release
        clear_counts();
        key[1] = 1'b0;
        for (int t = 0; t < 100 && cnt_press[1] == 0; t++) step(1);
        chk("s3_press_seen", 32'(cnt_press[1]), 32'd1);
        step(370);
        key[1] = 1'b1;
        step(60);
        chk("s3_long_once", 32'(cnt_long[1]), 32'd1);
        chk("s3_long_time", 32'(st_long[1] - st_press[1]), 32'(LONG * MS_CYC - 1));
        chk("s3_repeats", 32'(cnt_rep[1]), 32'd7);
        chk("s3_release_once", 32'(cnt_rel[1]), 32'd1);

        // 4: key[2] short press of random length
        clear_counts();
        hold = int'($urandom_range(10, 50));
        key[2] = 1'b0;
        for (int t = 0; t < 100 && cnt_press[2] == 0; t++) step(1);
        step(hold);
        key[2] = 1'b1;
        step(60);
        chk("s4_press_rel", 32'(cnt_press[2] * 16 + cnt_rel[2]), 32'h11);
        chk("s4_no_long_rep", 32'(cnt_long[2] + cnt_rep[2]), 32'd0);

        // 5: key[0] and key[5] fall together
        clear_counts();
        key[0] = 1'b0;
        key[5] = 1'b0;
        for (int t = 0; t < 200 && cnt_long[0] == 0; t++) step(1);
        chk("s5_press0_time", 32'(st_press[0]), 32'(st_press[5]));
        chk("s5_long0", 32'(st_long[0] - st_press[0]), 32'(LONG * MS_CYC - 1));
        chk("s5_long5", 32'(st_long[5] - st_press[0]), 32'(LONG * MS_CYC - 1));
        key[0] = 1'b1;
        key[5] = 1'b1;
        step(60);

        // 6: reset while key[3] is in HELD; fresh press after re-debounce
        clear_counts();
        key[3] = 1'b0;
        for (int t = 0; t < 200 && cnt_long[3] == 0; t++) step(1);
        chk("s6_long_seen", 32'(cnt_long[3]), 32'd1);
        step(15);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("s6_reset_state", 32'(key_state), 32'h3F);
        chk("s6_reset_pulses", 32'(press | release_evt | long_press | repeat_evt), 32'h0);
        clear_counts();
        for (int t = 0; t < 60 && cnt_press[3] == 0; t++) step(1);
        chk("s6_fresh_press", 32'(cnt_press[3]), 32'd1);
        chk("s6_press_time", 32'(st_press[3]), 32'(cyc - 0));
        chk("s6_no_release", 32'(cnt_rel[3]), 32'd0);
        key[3] = 1'b1;
        step(60);

        // 7: random activity on all keys
        for (int t = 0; t < 40; t++) begin
            key = N'($urandom);
            step(int'($urandom_range(1, 160)));
        end
        key = '1;
        step(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
